// File: rtl/mmio_timer_pkg.sv
// Register map and bit positions shared by the timer block and its submodules.
package mmio_timer_pkg;

    // Word index within the 16-byte window (Address[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN           = 0;
    localparam int unsigned CTRL_AUTO         = 1;
    localparam int unsigned CTRL_IRQ_EN       = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;

    // STATUS bit positions
    localparam int unsigned STATUS_EXPIRED = 0;
    localparam int unsigned STATUS_RUNNING = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] psc_q;
    logic [PRESCALE_W-1:0] psc_d;
    logic                  wrap;

    // Next prescaler value and tick; a CTRL write (clr_i) restarts the phase and swallows the tick
    always_comb begin
        wrap   = (psc_q == prescale_i);
        tick_o = en_i & wrap & ~clr_i;
        psc_d  = psc_q + PRESCALE_W'(1);
        if (clr_i || !en_i || wrap) begin
            psc_d = '0;
        end
    end

    // Prescaler state register
    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer on the CPU load/store bus: CTRL, LOAD, COUNT, STATUS.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1F00,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] Data,
    output logic        hit,
    output logic        irq
);

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  expired_q, expired_d;

    logic [1:0]  reg_sel;
    logic        wr_en;
    logic        ctrl_wr, load_wr, count_wr, status_wr;
    logic        tick;
    logic [31:0] ctrl_rd, status_rd;
    logic        unused_addr;

    // Byte lanes are not supported; the low address bits are deliberately ignored
    assign unused_addr = ^Address[1:0];

    // Address decode and per-register write strobes
    always_comb begin
        hit       = (Address[31:4] == BASE_ADDR[31:4]);
        reg_sel   = Address[3:2];
        wr_en     = hit & MemWrite;
        ctrl_wr   = wr_en & (reg_sel == REG_CTRL);
        load_wr   = wr_en & (reg_sel == REG_LOAD);
        count_wr  = wr_en & (reg_sel == REG_COUNT);
        status_wr = wr_en & (reg_sel == REG_STATUS);
    end

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_q),
        .clr_i      (ctrl_wr),
        .prescale_i (prescale_q),
        .tick_o     (tick)
    );

    // Combinational read mux; reads always see the pre-edge register contents
    always_comb begin
        ctrl_rd                                      = '0;
        ctrl_rd[CTRL_EN]                             = en_q;
        ctrl_rd[CTRL_AUTO]                           = auto_q;
        ctrl_rd[CTRL_IRQ_EN]                         = irq_en_q;
        ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W]     = prescale_q;
        status_rd                                    = '0;
        status_rd[STATUS_EXPIRED]                    = expired_q;
        status_rd[STATUS_RUNNING]                    = en_q;
        Data = '0;
        if (hit && MemRead) begin
            unique case (reg_sel)
                REG_CTRL:   Data = ctrl_rd;
                REG_LOAD:   Data = load_q;
                REG_COUNT:  Data = count_q;
                REG_STATUS: Data = status_rd;
                default:    Data = '0;
            endcase
        end
        irq = expired_q & irq_en_q;
    end

    // Register writes, countdown, reload and expiry; bus writes take priority over ticks
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        expired_d  = expired_q;

        if (ctrl_wr) begin
            en_d       = WriteData[CTRL_EN];
            auto_d     = WriteData[CTRL_AUTO];
            irq_en_d   = WriteData[CTRL_IRQ_EN];
            prescale_d = WriteData[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        if (load_wr) begin
            load_d = WriteData;
        end
        if (status_wr && WriteData[STATUS_EXPIRED]) begin
            expired_d = 1'b0;
        end

        if (count_wr) begin
            // A direct COUNT write consumes the tick entirely
            count_d = WriteData;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                // Set beats a simultaneous write-1 clear; reload uses the pre-edge LOAD
                expired_d = 1'b1;
                if (auto_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            load_q     <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            load_q     <= load_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus randomized bus traffic
// compared against a behavioural model of the timer.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1F00;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] Data;
    logic        hit;
    logic        irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_data;

    always #5 clk = ~clk;

    mmio_timer dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .Data      (Data),
        .hit       (hit),
        .irq       (irq)
    );

    // Behavioural model of the programmer-visible state
    bit        m_en, m_auto, m_ie, m_exp;
    bit [7:0]  m_pre, m_psc;
    bit [31:0] m_load, m_count;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {16'h0, m_pre, 5'h0, m_ie, m_auto, m_en};
            2'd1:    return m_load;
            2'd2:    return m_count;
            default: return {30'h0, m_en, m_exp};
        endcase
    endfunction

    // Advance the model across one rising edge given the bus inputs present at that edge
    task automatic model_step(input bit rst, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd);
        bit        w, ctrl_w, tick;
        bit        n_en, n_exp;
        bit [7:0]  n_psc;
        bit [31:0] n_count;
        if (rst) begin
            {m_en, m_auto, m_ie, m_exp} = '0;
            m_pre = 0; m_psc = 0; m_load = 0; m_count = 0;
            return;
        end
        w      = wr && m_hit(a);
        ctrl_w = w && a[3:2] == 2'd0;
        // The tick is the cycle on which the prescaler phase reaches PRESCALE
        tick   = m_en && (m_psc == m_pre) && !ctrl_w;
        n_psc  = (!m_en || ctrl_w) ? 8'd0 : 8'((int'(m_psc) + 1) % (int'(m_pre) + 1));
        n_en   = m_en;
        n_exp  = m_exp;
        n_count = m_count;
        if (w && a[3:2] == 2'd3 && wd[0]) n_exp = 0;
        if (w && a[3:2] == 2'd2) n_count = wd;
        else if (tick) begin
            if (m_count > 0) n_count = m_count - 1;
            else begin
                n_exp = 1;
                if (m_auto) n_count = m_load;
                else n_en = 0;
            end
        end
        if (ctrl_w) begin
            n_en   = wd[0];
            m_auto = wd[1];
            m_ie   = wd[2];
            m_pre  = wd[15:8];
        end
        if (w && a[3:2] == 2'd1) m_load = wd;
        m_en = n_en; m_exp = n_exp; m_count = n_count; m_psc = n_psc;
    endtask

    // One bus cycle: drive, compare outputs against the model mid-cycle, then clock
    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd);
        reset = rst; MemRead = rd; MemWrite = wr; Address = a; WriteData = wd;
        #2;
        last_data = Data;
        check_val("data", Data, rd ? m_read(a) : 32'h0);
        check_val("hit", {31'h0, hit}, {31'h0, m_hit(a)});
        check_val("irq", {31'h0, irq}, {31'h0, m_exp & m_ie});
        @(posedge clk);
        model_step(rst, wr, a, wd);
        #1;
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [31:0] v);
        cyc(1'b0, 1'b0, 1'b1, BASE + 32'(off), v);
    endtask

    task automatic bus_rd(input logic [3:0] off);
        cyc(1'b0, 1'b1, 1'b0, BASE + 32'(off), 32'h0);
    endtask

    initial begin
        logic [31:0] a, wd;
        bit          rd, wr, rst;
        int          r;

        reset = 1'b1; MemRead = 0; MemWrite = 0; Address = 0; WriteData = 0;
        @(posedge clk);
        model_step(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // 1. Reset state and window decode
        for (int i = 0; i < 4; i++) begin
            bus_rd(4'(i * 4));
            check_val("t1 reset read", last_data, 32'h0);
        end
        cyc(1'b0, 1'b1, 1'b0, BASE + 32'h10, 32'h0);
        check_val("t1 outside hit", {31'h0, hit}, 32'h0);
        check_val("t1 outside data", last_data, 32'h0);

        // 2. One-shot, PRESCALE=0
        bus_wr(4'h4, 32'd3);
        bus_wr(4'h8, 32'd3);
        bus_wr(4'h0, 32'h005);
        for (int i = 3; i >= 0; i--) begin
            bus_rd(4'h8);
            check_val("t2 count seq", last_data, 32'(i));
        end
        bus_rd(4'hC);
        check_val("t2 status", last_data, 32'h1);
        check_val("t2 irq", {31'h0, irq}, 32'h1);
        bus_rd(4'h0);
        check_val("t2 ctrl en cleared", last_data, 32'h004);
        bus_rd(4'h8);
        check_val("t2 count hold", last_data, 32'h0);

        // 3. Auto-reload, PRESCALE=2
        bus_wr(4'hC, 32'h1);
        bus_wr(4'h4, 32'd1);
        bus_wr(4'h8, 32'd1);
        bus_wr(4'h0, 32'h203);
        for (int i = 0; i < 6; i++) begin
            bus_rd(4'h8);
            check_val("t3 count seq", last_data, (i < 3) ? 32'd1 : 32'd0);
        end
        bus_rd(4'hC);
        check_val("t3 status exp+run", last_data, 32'h3);

        // 4. Sticky EXPIRED and clear priority
        bus_wr(4'h0, 32'h004);
        bus_wr(4'hC, 32'h0);
        bus_rd(4'hC);
        check_val("t4 write0 keeps", last_data, 32'h1);
        bus_wr(4'hC, 32'h1);
        bus_rd(4'hC);
        check_val("t4 write1 clears", last_data, 32'h0);
        check_val("t4 irq low", {31'h0, irq}, 32'h0);
        bus_wr(4'h4, 32'd0);
        bus_wr(4'h8, 32'd0);
        bus_wr(4'h0, 32'h005);
        bus_wr(4'hC, 32'h1);
        bus_rd(4'hC);
        check_val("t4 set beats clear", last_data, 32'h1);

        // 5. COUNT write beats tick; EN=0 freezes
        bus_wr(4'h8, 32'd100);
        bus_wr(4'h0, 32'h001);
        bus_rd(4'h8);
        bus_wr(4'h8, 32'd10);
        bus_rd(4'h8);
        check_val("t5 write wins", last_data, 32'd10);
        bus_wr(4'h0, 32'h000);
        for (int i = 0; i < 20; i++) begin
            bus_rd(4'h8);
            check_val("t5 frozen", last_data, 32'd9);
        end

        // 6. Reset mid-count
        bus_wr(4'h8, 32'd6);
        bus_wr(4'h0, 32'h005);
        bus_rd(4'h8);
        check_val("t6 irq before reset", {31'h0, irq}, 32'h1);
        cyc(1'b1, 1'b1, 1'b0, BASE + 32'h8, 32'h0);
        check_val("t6 count at reset", last_data, 32'd5);
        check_val("t6 irq after reset", {31'h0, irq}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_rd(4'(i * 4));
            check_val("t6 cleared", last_data, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            bus_rd(4'h8);
            check_val("t6 no tick", last_data, 32'h0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            r   = int'($urandom_range(0, 99));
            a   = (r < 6) ? $urandom : BASE + {28'h0, 2'($urandom_range(0, 3)), 2'($urandom)};
            rd  = $urandom_range(0, 1) == 1;
            wr  = $urandom_range(0, 3) == 0;
            rst = $urandom_range(0, 199) == 0;
            wd  = $urandom;
            case (a[3:2])
                2'd0:    wd = wd & ~32'h0000_FC00;     // keep PRESCALE small
                2'd1,
                2'd2:    wd = 32'($urandom_range(0, 6));
                default: wd = wd;
            endcase
            cyc(rst, rd, wr, a, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
